// File: rtl/imem_pkg.sv
// imem_pkg: shared types, fault codes and helpers for the instruction fetch memory
package imem_pkg;
  typedef enum logic [1:0] {CLEAR = 2'b00, LOAD = 2'b01, RUN = 2'b10} state_t;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 single-write-port RAM with registered, enable-held read
module imem_array #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  // storage write; contents are initialised by the owner's clear sweep
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register only updates on enable so the last word is held
  always_ff @(posedge clk)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: run-time loadable instruction memory with fault-checked fetch; optional FETCH_COUNT_EN adds fetch_count
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  input  logic                     prog_done,
  input  logic                     prog_start,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [31:0]              fetch_instr,
  output logic                     fetch_fault,
  output logic [1:0]               fault_cause,
  output logic [1:0]               state_o
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]              fetch_count
`endif
);
  localparam int AW = idx_w(DEPTH);
  state_t state;
  logic [AW-1:0] clr_cnt;
  logic clearing, accept, misaligned, out_range, we, re, nop_sel;
  logic [1:0] cause;
  logic [AW-1:0] waddr;
  logic [31:0] wdata, rdata;
  assign clearing    = state != LOAD && state != RUN;
  assign fetch_ready = state == RUN;
  assign accept      = fetch_req & fetch_ready;
  assign misaligned  = |fetch_addr[1:0];
  assign out_range   = |fetch_addr[ADDR_W-1:AW+2];
  assign cause       = misaligned ? CAUSE_MISALIGN : out_range ? CAUSE_RANGE : CAUSE_NONE;
  assign we          = clearing | (state == LOAD & prog_we);
  assign waddr       = clearing ? clr_cnt : prog_addr;
  assign wdata       = clearing ? '0 : prog_data;
  assign re          = accept & (cause == CAUSE_NONE);
  assign fetch_instr = nop_sel ? NOP_INSTR : rdata;
  assign state_o     = state;
  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(fetch_addr[AW+1:2]), .rdata(rdata)
  );
  // CLEAR sweeps every word once, then LOAD/RUN toggle under program control
  always_ff @(posedge clk)
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else
      case (state)
        LOAD: if (prog_done) state <= RUN;
        RUN:  if (prog_start) state <= LOAD;
        default: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) state <= LOAD;
        end
      endcase
  // response stage; nop_sel persists so fetch_instr holds between responses
  always_ff @(posedge clk)
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= CAUSE_NONE;
      nop_sel     <= 1'b0;
    end else begin
      fetch_valid <= accept;
      fetch_fault <= accept & (cause != CAUSE_NONE);
      fault_cause <= accept ? cause : CAUSE_NONE;
      if (accept) nop_sel <= cause != CAUSE_NONE;
    end
`ifdef FETCH_COUNT_EN
  // saturating count of good responses, restarted when a new program starts running
  always_ff @(posedge clk)
    if (reset || (state == LOAD && prog_done)) fetch_count <= '0;
    else if (fetch_valid && !fetch_fault && !(&fetch_count)) fetch_count <= fetch_count + 1'b1;
`endif
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed self-checking bench for instr_fetch_mem (DEPTH=64)
module tb_instr_fetch_mem;
  logic clk = 0, reset = 1, prog_we = 0, prog_done = 0, prog_start = 0, fetch_req = 0;
  logic [5:0] prog_addr = 0;
  logic [31:0] prog_data = 0, fetch_addr = 0;
  logic fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_instr;
  logic [1:0] fault_cause, state_o;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif
  int compared = 0, mismatched = 0;

  instr_fetch_mem dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_done(prog_done), .prog_start(prog_start), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause), .state_o(state_o)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input string name, input logic v, input logic f, input logic [1:0] c, input logic [31:0] i);
    compared++;
    if (fetch_valid !== v || fetch_fault !== f || fault_cause !== c || fetch_instr !== i) begin
      mismatched++;
      $display("FAIL %s: got valid=%b fault=%b cause=%b instr=%h, want valid=%b fault=%b cause=%b instr=%h",
               name, fetch_valid, fetch_fault, fault_cause, fetch_instr, v, f, c, i);
    end
  endtask

  task automatic reset_and_clear();
    int bad;
    reset = 1;
    tick();
    reset = 0;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (state_o !== 2'b00 || fetch_ready !== 1'b0) bad++;
      tick();
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL clear_period: %0d bad cycles, want 0", bad);
    end
    compared++;
    if (state_o !== 2'b01 || fetch_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL enter_load: state=%b ready=%b, want state=01 ready=0", state_o, fetch_ready);
    end
  endtask

  task automatic write_word(input logic [5:0] a, input logic [31:0] d, input logic done);
    prog_we = 1; prog_addr = a; prog_data = d; prog_done = done;
    tick();
    prog_we = 0; prog_done = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1; fetch_addr = a;
    tick();
    fetch_req = 0;
  endtask

  task automatic test_reset();
    tick();
    compared++;
    if (state_o !== 2'b00 || fetch_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: state=%b ready=%b, want 00/0", state_o, fetch_ready);
    end
    resp("reset_outputs", 0, 0, 2'b00, 32'h0);
    reset_and_clear();
    tick();
    tick();
    compared++;
    if (fetch_ready !== 1'b0 || state_o !== 2'b01) begin
      mismatched++;
      $display("FAIL load_idle: ready=%b state=%b, want 0/01", fetch_ready, state_o);
    end
    prog_done = 1;
    tick();
    prog_done = 0;
    compared++;
    if (fetch_ready !== 1'b1 || state_o !== 2'b10) begin
      mismatched++;
      $display("FAIL enter_run: ready=%b state=%b, want 1/10", fetch_ready, state_o);
    end
    fetch(32'd20);
    resp("cleared_word5", 1, 0, 2'b00, 32'h0);
  endtask

  task automatic test_load_fetch();
    prog_start = 1;
    tick();
    prog_start = 0;
    write_word(6'd0, 32'h0010_0133, 0);
    write_word(6'd1, 32'h000A_2183, 1);
    compared++;
    if (state_o !== 2'b10) begin
      mismatched++;
      $display("FAIL run_after_done: state=%b, want 10", state_o);
    end
    fetch_req = 1; fetch_addr = 0;
    tick();
    resp("b2b_word0", 1, 0, 2'b00, 32'h0010_0133);
    fetch_addr = 4;
    tick();
    fetch_req = 0;
    resp("b2b_word1", 1, 0, 2'b00, 32'h000A_2183);
    tick();
    resp("idle_hold", 0, 0, 2'b00, 32'h000A_2183);
  endtask

  task automatic test_faults();
    fetch(32'h6);
    resp("misaligned", 1, 1, 2'b01, 32'h0000_0013);
    tick();
    resp("hold_nop", 0, 0, 2'b00, 32'h0000_0013);
    fetch(32'h100);
    resp("out_of_range", 1, 1, 2'b10, 32'h0000_0013);
    fetch(32'h8000_0000);
    resp("high_bit_range", 1, 1, 2'b10, 32'h0000_0013);
    fetch(32'h102);
    resp("misalign_priority", 1, 1, 2'b01, 32'h0000_0013);
    fetch(32'hFC);
    resp("last_word", 1, 0, 2'b00, 32'h0);
  endtask

  task automatic test_write_protect();
    prog_we = 1; prog_addr = 0; prog_data = 32'hFFFF_FFFF;
    tick();
    prog_we = 0;
    fetch(32'h0);
    resp("write_protect", 1, 0, 2'b00, 32'h0010_0133);
    fetch_req = 1; fetch_addr = 4; prog_start = 1;
    tick();
    prog_start = 0;
    resp("fetch_with_start", 1, 0, 2'b00, 32'h000A_2183);
    compared++;
    if (state_o !== 2'b01 || fetch_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL back_to_load: state=%b ready=%b, want 01/0", state_o, fetch_ready);
    end
    tick();
    fetch_req = 0;
    resp("no_fetch_in_load", 0, 0, 2'b00, 32'h000A_2183);
    write_word(6'd0, 32'h0000_0033, 1);
    fetch(32'h0);
    resp("rewrite_word0", 1, 0, 2'b00, 32'h0000_0033);
    fetch(32'h4);
    resp("no_reclear", 1, 0, 2'b00, 32'h000A_2183);
  endtask

  task automatic test_reset_mid_stream();
    fetch_req = 1; fetch_addr = 0;
    tick();
    fetch_addr = 4;
    reset = 1;
    tick();
    fetch_req = 0;
    resp("reset_drops_resp", 0, 0, 2'b00, 32'h0);
    compared++;
    if (state_o !== 2'b00 || fetch_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_state: state=%b ready=%b, want 00/0", state_o, fetch_ready);
    end
    reset = 0;
    tick();
    resp("after_reset_idle", 0, 0, 2'b00, 32'h0);
  endtask

`ifdef FETCH_COUNT_EN
  task automatic test_fetch_count();
    reset_and_clear();
    write_word(6'd0, 32'h0000_0033, 1);
    compared++;
    if (fetch_count !== 32'd0) begin
      mismatched++;
      $display("FAIL count_start: got %0d want 0", fetch_count);
    end
    fetch_req = 1; fetch_addr = 0;
    tick();
    tick();
    tick();
    fetch_addr = 32'h6;
    tick();
    fetch_req = 0;
    tick();
    tick();
    compared++;
    if (fetch_count !== 32'd3) begin
      mismatched++;
      $display("FAIL fetch_count: got %0d want 3", fetch_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_fetch();
    test_faults();
    test_write_protect();
    test_reset_mid_stream();
`ifdef FETCH_COUNT_EN
    test_fetch_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
